// File: rtl/fpu_multiplier.sv
// fpu_multiplier: multi-cycle IEEE-754 binary32 multiplier, round-to-nearest-even.
// Both operands are captured on a joint strobe. The registered result is
// qualified by a one-clock output_z_stb pulse.
// Optional feature macro: FPU_MULTIPLIER_DENORMAL_EN
//   undefined: subnormal inputs and tiny results are flushed to signed zero.
//   defined:   gradual underflow through shift loops, giving variable latency.
module fpu_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic [31:0] output_z,
    output logic        output_z_stb
);

    typedef enum logic [3:0] {
        IDLE, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, PUT_Z
`ifdef FPU_MULTIPLIER_DENORMAL_EN
        , NORMALISE_A, NORMALISE_B, UNDERFLOW
`endif
    } state_t;

    state_t             r_state, w_next_state;
    logic [31:0]        r_a, r_b;
    logic [23:0]        r_a_m, r_b_m, r_m;
    logic signed [9:0]  r_a_e, r_b_e, r_e;
    logic               r_sign, r_g, r_r, r_s;
    logic [47:0]        r_prod;

    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_special;
    logic [31:0] w_special_z, w_pack_z;
    logic [47:0] w_prod_n;
    logic signed [9:0] w_e_norm;
    logic        w_round_up;
    logic [24:0] w_m_inc;
    logic [7:0]  w_exp_field;

    // Operand classification from the captured raw words
    always_comb begin
        w_a_nan  = (&r_a[30:23]) & (|r_a[22:0]);
        w_b_nan  = (&r_b[30:23]) & (|r_b[22:0]);
        w_a_inf  = (&r_a[30:23]) & ~(|r_a[22:0]);
        w_b_inf  = (&r_b[30:23]) & ~(|r_b[22:0]);
`ifdef FPU_MULTIPLIER_DENORMAL_EN
        w_a_zero = (r_a[30:23] == 8'd0) & ~(|r_a[22:0]);
        w_b_zero = (r_b[30:23] == 8'd0) & ~(|r_b[22:0]);
`else
        w_a_zero = (r_a[30:23] == 8'd0);
        w_b_zero = (r_b[30:23] == 8'd0);
`endif
        w_special   = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
        w_special_z = {r_sign, 31'd0};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            w_special_z = 32'h7FC00000;
        else if (w_a_inf || w_b_inf)
            w_special_z = {r_sign, 8'hFF, 23'd0};
    end

    // Normalise, round and pack arithmetic
    always_comb begin
        w_prod_n    = r_prod[47] ? r_prod : {r_prod[46:0], 1'b0};
        w_e_norm    = r_prod[47] ? r_e : r_e - 10'sd1;
        w_round_up  = r_g & (r_r | r_s | r_m[0]);
        w_m_inc     = {1'b0, r_m} + 25'd1;
        w_exp_field = r_e[7:0] + 8'd127;
        if (r_e > 10'sd127)
            w_pack_z = {r_sign, 8'hFF, 23'd0};
`ifdef FPU_MULTIPLIER_DENORMAL_EN
        else if (r_e == -10'sd126 && !r_m[23])
            w_pack_z = {r_sign, 8'h00, r_m[22:0]};
`else
        else if (r_e < -10'sd126)
            w_pack_z = {r_sign, 31'd0};
`endif
        else
            w_pack_z = {r_sign, w_exp_field, r_m[22:0]};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state sequencing
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:      if (input_a_stb && input_b_stb) w_next_state = UNPACK;
            UNPACK:    w_next_state = SPECIAL;
`ifdef FPU_MULTIPLIER_DENORMAL_EN
            SPECIAL: begin
                if (w_special)      w_next_state = PUT_Z;
                else if (!r_a_m[23]) w_next_state = NORMALISE_A;
                else if (!r_b_m[23]) w_next_state = NORMALISE_B;
                else                 w_next_state = MULTIPLY;
            end
            NORMALISE_A: if (r_a_m[22]) w_next_state = r_b_m[23] ? MULTIPLY : NORMALISE_B;
            NORMALISE_B: if (r_b_m[22]) w_next_state = MULTIPLY;
            NORMALISE:   w_next_state = (w_e_norm < -10'sd126) ? UNDERFLOW : ROUND;
            UNDERFLOW:   if (r_e == -10'sd127) w_next_state = ROUND;
`else
            SPECIAL:   w_next_state = w_special ? PUT_Z : MULTIPLY;
            NORMALISE: w_next_state = ROUND;
`endif
            MULTIPLY:  w_next_state = NORMALISE;
            ROUND:     w_next_state = PACK;
            PACK:      w_next_state = PUT_Z;
            PUT_Z:     w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Datapath registers and result output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= '0; r_b <= '0; r_a_m <= '0; r_b_m <= '0; r_m <= '0;
            r_a_e <= '0; r_b_e <= '0; r_e <= '0; r_prod <= '0;
            r_sign <= 1'b0; r_g <= 1'b0; r_r <= 1'b0; r_s <= 1'b0;
            output_z <= '0; output_z_stb <= 1'b0;
        end else begin
            output_z_stb <= 1'b0;
            case (r_state)
                IDLE: if (input_a_stb && input_b_stb) begin
                    r_a <= input_a;
                    r_b <= input_b;
                end
                // A zero exponent field is an unbiased -126 without hidden bit
                UNPACK: begin
                    r_sign <= r_a[31] ^ r_b[31];
                    r_a_m  <= {|r_a[30:23], r_a[22:0]};
                    r_b_m  <= {|r_b[30:23], r_b[22:0]};
                    r_a_e  <= (r_a[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, r_a[30:23]}) - 10'sd127;
                    r_b_e  <= (r_b[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, r_b[30:23]}) - 10'sd127;
                end
                SPECIAL: if (w_special) begin
                    output_z     <= w_special_z;
                    output_z_stb <= 1'b1;
                end
`ifdef FPU_MULTIPLIER_DENORMAL_EN
                NORMALISE_A: begin
                    r_a_m <= {r_a_m[22:0], 1'b0};
                    r_a_e <= r_a_e - 10'sd1;
                end
                NORMALISE_B: begin
                    r_b_m <= {r_b_m[22:0], 1'b0};
                    r_b_e <= r_b_e - 10'sd1;
                end
                UNDERFLOW: begin
                    {r_m, r_g, r_r} <= {1'b0, r_m, r_g};
                    r_s <= r_s | r_r;
                    r_e <= r_e + 10'sd1;
                end
`endif
                MULTIPLY: begin
                    r_prod <= r_a_m * r_b_m;
                    r_e    <= r_a_e + r_b_e + 10'sd1;
                end
                NORMALISE: begin
                    r_m <= w_prod_n[47:24];
                    r_g <= w_prod_n[23];
                    r_r <= w_prod_n[22];
                    r_s <= |w_prod_n[21:0];
                    r_e <= w_e_norm;
                end
                ROUND: if (w_round_up) begin
                    if (w_m_inc[24]) begin
                        r_m <= w_m_inc[24:1];
                        r_e <= r_e + 10'sd1;
                    end else begin
                        r_m <= w_m_inc[23:0];
                    end
                end
                PACK: begin
                    output_z     <= w_pack_z;
                    output_z_stb <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_multiplier.sv
// Directed, table-driven bench for fpu_multiplier.
// Latency is counted in rising edges with the capture edge as edge 1.
module tb_fpu_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] input_a = '0, input_b = '0;
    logic        input_a_stb = 1'b0, input_b_stb = 1'b0;
    logic [31:0] output_z;
    logic        output_z_stb;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fpu_multiplier dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .output_z     (output_z),
        .output_z_stb (output_z_stb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        int unsigned lat;
    } vec_t;

    localparam int unsigned NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] z, input int unsigned lat);
        int unsigned edge_n;
        logic        seen;
        @(negedge clk);
        input_a = a; input_b = b; input_a_stb = 1'b1; input_b_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0; input_b_stb = 1'b0;
        edge_n = 1;
        seen   = output_z_stb;
        while (!seen && edge_n < 400) begin
            @(posedge clk); #1;
            edge_n++;
            seen = output_z_stb;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no output_z_stb within 400 edges", name);
        end else begin
            check({name, " latency"}, edge_n, lat);
            check({name, " z"}, output_z, z);
            @(posedge clk); #1;
            check({name, " stb one-wide"}, {31'd0, output_z_stb}, 32'd0);
            check({name, " z held"}, output_z, z);
        end
    endtask

    task automatic count_strobes(input int unsigned n_edges, output int unsigned cnt);
        cnt = 0;
        for (int unsigned i = 0; i < n_edges; i++) begin
            @(posedge clk); #1;
            if (output_z_stb) cnt++;
        end
    endtask

    initial begin
        int unsigned cnt;

        vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 7};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 7};
        vecs[2]  = '{32'h3F000000, 32'h3F000000, 32'h3E800000, 7};
        vecs[3]  = '{32'hC0000000, 32'h40800000, 32'hC1000000, 7};
        vecs[4]  = '{32'h00000000, 32'h40A00000, 32'h00000000, 3};
        vecs[5]  = '{32'h80000000, 32'h40A00000, 32'h80000000, 3};
        vecs[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3};
        vecs[7]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3};
        vecs[8]  = '{32'h7F800000, 32'hBF800000, 32'hFF800000, 3};
        vecs[9]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 7};
        vecs[10] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 7};
        vecs[11] = '{32'h3F7FFFFF, 32'h3F7FFFFF, 32'h3F7FFFFE, 7};
        vecs[12] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 7};
        vecs[13] = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 3};
`ifdef FPU_MULTIPLIER_DENORMAL_EN
        vecs[14] = '{32'h00800000, 32'h3F000000, 32'h00400000, 8};
        vecs[15] = '{32'h00000001, 32'h3F800000, 32'h00000001, 53};
`else
        vecs[14] = '{32'h00800000, 32'h3F000000, 32'h00000000, 7};
        vecs[15] = '{32'h80000001, 32'h3F800000, 32'h80000000, 3};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset z", output_z, 32'h0);
        check("reset stb", {31'd0, output_z_stb}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int unsigned i = 0; i < NVEC; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].lat);

        // Reset asserted mid-operation discards the result
        @(negedge clk);
        input_a = 32'h40000000; input_b = 32'h40400000;
        input_a_stb = 1'b1; input_b_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0; input_b_stb = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midop reset z", output_z, 32'h0);
        check("midop reset stb", {31'd0, output_z_stb}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        count_strobes(12, cnt);
        check("midop reset no stray stb", cnt, 32'd0);
        run_op("after reset", 32'h40000000, 32'h40400000, 32'h40C00000, 7);

        // A single strobe alone is ignored
        @(negedge clk);
        input_a = 32'h3F800000; input_a_stb = 1'b1;
        count_strobes(5, cnt);
        @(negedge clk);
        input_a_stb = 1'b0;
        begin
            int unsigned cnt2;
            count_strobes(12, cnt2);
            check("single strobe no result", cnt + cnt2, 32'd0);
        end

        // Both strobes held for three edges produce exactly one result
        @(negedge clk);
        input_a = 32'hC0000000; input_b = 32'h40800000;
        input_a_stb = 1'b1; input_b_stb = 1'b1;
        count_strobes(3, cnt);
        input_a_stb = 1'b0; input_b_stb = 1'b0;
        begin
            int unsigned cnt2;
            count_strobes(20, cnt2);
            check("held strobes one result", cnt + cnt2, 32'd1);
        end
        check("held strobes z", output_z, 32'hC1000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
